// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice.
// Contents:
//   seq_state_t - run/halt handshake states
//   pc_op_t     - next-PC selection codes shared by the top and prog_counter
//   MODE_*      - decoder operand modes carried in CurrState
//   NOP_INSTR   - instruction word presented to the decoder while not running
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_RUN  = 2'b01,
        SEQ_HALT = 2'b10
    } seq_state_t;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_REL  = 3'd2,
        PC_ABS  = 3'd3,
        PC_LOAD = 3'd4
    } pc_op_t;

    localparam logic [1:0] MODE_REG    = 2'b00;
    localparam logic [1:0] MODE_TARGET = 2'b01;
    localparam logic [1:0] MODE_IMM    = 2'b10;
    localparam logic [1:0] MODE_NOP    = 2'b11;

    localparam logic [8:0] NOP_INSTR   = 9'b0_0000_0000;

endpackage

// File: rtl/fetch_sequencer_prog_counter.sv
// Program counter register with its next-PC selection.
// Ports:
//   clk    in  1     rising-edge clock
//   reset  in  1     synchronous active-high reset, loads START_ADDR
//   pc_op  in  3     pc_op_t code: hold / +1 / +offset / =offset / =START_ADDR
//   offset in  PC_W  branch target or forward offset, already fitted to PC_W
//   pc     out PC_W  current program counter (registered)
// All arithmetic is modulo 2**PC_W; overflow wraps silently.
module prog_counter
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      pc_op,
    input  logic [PC_W-1:0] offset,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_nxt_s;

    // Next-PC mux; the adders are PC_W wide so wrap-around is implicit.
    always_comb begin
        pc_nxt_s = pc_r;
        case (pc_op)
            PC_HOLD: pc_nxt_s = pc_r;
            PC_INC:  pc_nxt_s = pc_r + PC_W'(1);
            PC_REL:  pc_nxt_s = pc_r + offset;
            PC_ABS:  pc_nxt_s = offset;
            PC_LOAD: pc_nxt_s = PC_W'(START_ADDR);
            default: pc_nxt_s = pc_r;
        endcase
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= PC_W'(START_ADDR);
        end else begin
            pc_r <= pc_nxt_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-flow stage in front of the control decoder.
// Holds the PC, the Req/Done run handshake and the decoder's state that must
// survive between instructions (mode, previous instruction, compare flags).
// Ports:
//   Clk, Reset             clock and synchronous active-high reset
//   Req                    start request, honoured only while idle or halted
//   InstrIn                ROM data at ProgCtr (combinational ROM)
//   BranchEn/BranchAbs/BranchTarget  decoder branch request
//   NextState, PrevInstrIn, CMPLoadEn, CMPBitsIn  decoder state feedback
//   AckIn                  decoder reports end of program
//   ProgCtr                ROM address
//   Instruction            InstrIn while running, NOP otherwise
//   CurrState              decoder mode (reads MODE_REG when not running)
//   PrevInstruction, CMPBits  registered decoder feedback
//   Running, Done          handshake status
//   CycleCnt               saturating count of RUN cycles of the current/last program
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int CYC_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req,
    input  logic [8:0]       InstrIn,
    input  logic             BranchEn,
    input  logic             BranchAbs,
    input  logic [8:0]       BranchTarget,
    input  logic [1:0]       NextState,
    input  logic [8:0]       PrevInstrIn,
    input  logic             CMPLoadEn,
    input  logic [2:0]       CMPBitsIn,
    input  logic             AckIn,
    output logic [PC_W-1:0]  ProgCtr,
    output logic [8:0]       Instruction,
    output logic [1:0]       CurrState,
    output logic [8:0]       PrevInstruction,
    output logic [2:0]       CMPBits,
    output logic             Running,
    output logic             Done,
    output logic [CYC_W-1:0] CycleCnt
);

    seq_state_t       state_r;
    seq_state_t       state_nxt_s;
    logic             start_run_s;
    logic             run_s;
    logic             adv_s;
    logic [2:0]       pc_op_s;
    logic [PC_W-1:0]  target_s;
    logic [1:0]       curr_state_r;
    logic [8:0]       prev_instr_r;
    logic [2:0]       cmp_bits_r;
    logic [CYC_W-1:0] cycle_cnt_r;

    // Status decode. An unreachable encoding behaves like idle so Req recovers it.
    always_comb begin
        run_s       = (state_r == SEQ_RUN);
        start_run_s = 1'b0;
        if ((state_r != SEQ_RUN) && Req) begin
            start_run_s = 1'b1;
        end else begin
            start_run_s = 1'b0;
        end
        // Ack freezes the architectural state in the same cycle it halts.
        adv_s = run_s && !AckIn;
    end

    // Handshake FSM; Req is not looked at while running, so Req+Ack halts.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SEQ_IDLE: begin
                if (Req) state_nxt_s = SEQ_RUN;
                else     state_nxt_s = SEQ_IDLE;
            end
            SEQ_RUN: begin
                if (AckIn) state_nxt_s = SEQ_HALT;
                else       state_nxt_s = SEQ_RUN;
            end
            SEQ_HALT: begin
                if (Req) state_nxt_s = SEQ_RUN;
                else     state_nxt_s = SEQ_HALT;
            end
            default: begin
                if (Req) state_nxt_s = SEQ_RUN;
                else     state_nxt_s = SEQ_IDLE;
            end
        endcase
    end

    // Width cast truncates a wide target or zero-extends a narrow one.
    assign target_s = PC_W'(BranchTarget);

    // PC operation select; Ack outranks a branch issued in the same cycle.
    always_comb begin
        pc_op_s = PC_HOLD;
        if (start_run_s) begin
            pc_op_s = PC_LOAD;
        end else if (adv_s && BranchEn) begin
            if (BranchAbs) pc_op_s = PC_ABS;
            else           pc_op_s = PC_REL;
        end else if (adv_s) begin
            pc_op_s = PC_INC;
        end else begin
            pc_op_s = PC_HOLD;
        end
    end

    prog_counter #(
        .PC_W       (PC_W),
        .START_ADDR (START_ADDR)
    ) u_prog_counter (
        .clk    (Clk),
        .reset  (Reset),
        .pc_op  (pc_op_s),
        .offset (target_s),
        .pc     (ProgCtr)
    );

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= SEQ_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Decoder inter-instruction state: cleared on program start, held when not advancing.
    always_ff @(posedge Clk) begin
        if (Reset || start_run_s) begin
            curr_state_r <= MODE_REG;
            prev_instr_r <= NOP_INSTR;
            cmp_bits_r   <= 3'b000;
        end else if (adv_s) begin
            curr_state_r <= NextState;
            prev_instr_r <= PrevInstrIn;
            if (CMPLoadEn) cmp_bits_r <= CMPBitsIn;
            else           cmp_bits_r <= cmp_bits_r;
        end else begin
            curr_state_r <= curr_state_r;
            prev_instr_r <= prev_instr_r;
            cmp_bits_r   <= cmp_bits_r;
        end
    end

    // Run-cycle counter, counts the Ack cycle too and sticks at all-ones.
    always_ff @(posedge Clk) begin
        if (Reset || start_run_s) begin
            cycle_cnt_r <= {CYC_W{1'b0}};
        end else if (run_s && (cycle_cnt_r != {CYC_W{1'b1}})) begin
            cycle_cnt_r <= cycle_cnt_r + CYC_W'(1);
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign Running         = run_s;
    assign Done            = (state_r == SEQ_HALT);
    assign Instruction     = run_s ? InstrIn : NOP_INSTR;
    assign CurrState       = run_s ? curr_state_r : MODE_REG;
    assign PrevInstruction = prev_instr_r;
    assign CMPBits         = cmp_bits_r;
    assign CycleCnt        = cycle_cnt_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model of the sequencer's rules.
module tb_fetch_sequencer;

    localparam int PC_W  = 10;
    localparam int CYC_W = 8;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CYC_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Req = 1'b0;
    logic [8:0]       InstrIn;
    logic             BranchEn = 1'b0;
    logic             BranchAbs = 1'b0;
    logic [8:0]       BranchTarget = 9'd0;
    logic [1:0]       NextState = 2'b00;
    logic [8:0]       PrevInstrIn = 9'd0;
    logic             CMPLoadEn = 1'b0;
    logic [2:0]       CMPBitsIn = 3'b000;
    logic             AckIn = 1'b0;
    logic [PC_W-1:0]  ProgCtr;
    logic [8:0]       Instruction;
    logic [1:0]       CurrState;
    logic [8:0]       PrevInstruction;
    logic [2:0]       CMPBits;
    logic             Running;
    logic             Done;
    logic [CYC_W-1:0] CycleCnt;

    logic [8:0] rom [PC_MOD];

    int tests = 0;
    int fails = 0;

    // Model: 0 idle, 1 running, 2 halted.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cs   = 0;
    int m_prev = 0;
    int m_cmp  = 0;
    int m_cnt  = 0;
    bit m_valid = 1'b0;

    always #5 Clk = ~Clk;

    assign InstrIn = rom[ProgCtr];

    fetch_sequencer #(
        .PC_W       (PC_W),
        .START_ADDR (0),
        .CYC_W      (CYC_W)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Req             (Req),
        .InstrIn         (InstrIn),
        .BranchEn        (BranchEn),
        .BranchAbs       (BranchAbs),
        .BranchTarget    (BranchTarget),
        .NextState       (NextState),
        .PrevInstrIn     (PrevInstrIn),
        .CMPLoadEn       (CMPLoadEn),
        .CMPBitsIn       (CMPBitsIn),
        .AckIn           (AckIn),
        .ProgCtr         (ProgCtr),
        .Instruction     (Instruction),
        .CurrState       (CurrState),
        .PrevInstruction (PrevInstruction),
        .CMPBits         (CMPBits),
        .Running         (Running),
        .Done            (Done),
        .CycleCnt        (CycleCnt)
    );

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model, advanced on every rising edge from the inputs in force.
    always @(posedge Clk) begin
        if (Reset) begin
            m_mode = 0; m_pc = 0; m_cs = 0; m_prev = 0; m_cmp = 0; m_cnt = 0;
            m_valid = 1'b1;
        end else if (m_mode != 1) begin
            if (Req) begin
                m_mode = 1; m_pc = 0; m_cs = 0; m_prev = 0; m_cmp = 0; m_cnt = 0;
            end
        end else begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (AckIn) begin
                m_mode = 2;
            end else begin
                if (BranchEn && BranchAbs) m_pc = int'(BranchTarget) % PC_MOD;
                else if (BranchEn)         m_pc = (m_pc + int'(BranchTarget)) % PC_MOD;
                else                       m_pc = (m_pc + 1) % PC_MOD;
                m_cs   = int'(NextState);
                m_prev = int'(PrevInstrIn);
                if (CMPLoadEn) m_cmp = int'(CMPBitsIn);
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge Clk) begin
        if (m_valid) begin
            check("ProgCtr",         int'(ProgCtr),         m_pc);
            check("Running",         int'(Running),         (m_mode == 1) ? 1 : 0);
            check("Done",            int'(Done),            (m_mode == 2) ? 1 : 0);
            check("Instruction",     int'(Instruction),     (m_mode == 1) ? int'(rom[m_pc]) : 0);
            check("CurrState",       int'(CurrState),       (m_mode == 1) ? m_cs : 0);
            check("PrevInstruction", int'(PrevInstruction), m_prev);
            check("CMPBits",         int'(CMPBits),         m_cmp);
            check("CycleCnt",        int'(CycleCnt),        m_cnt);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < PC_MOD; i++) rom[i] = 9'($urandom);

        // Reset
        repeat (3) step();
        Reset = 1'b0;
        check("rst_pc", int'(ProgCtr), 0);
        check("rst_running", int'(Running), 0);
        check("rst_done", int'(Done), 0);
        check("rst_cnt", int'(CycleCnt), 0);
        step();

        // Start: PC 0 then 1,2,3
        Req = 1'b1;
        step();
        Req = 1'b0;
        check("start_pc0", int'(ProgCtr), 0);
        check("start_running", int'(Running), 1);
        check("start_instr", int'(Instruction), int'(rom[0]));
        repeat (3) step();
        check("seq_pc3", int'(ProgCtr), 3);
        repeat (2) step();
        check("seq_pc5", int'(ProgCtr), 5);

        // Relative then absolute branch
        BranchEn = 1'b1; BranchAbs = 1'b0; BranchTarget = 9'd2;
        step();
        check("rel_branch", int'(ProgCtr), 7);
        BranchAbs = 1'b1; BranchTarget = 9'h1F0;
        step();
        check("abs_branch", int'(ProgCtr), 'h1F0);
        BranchEn = 1'b0; BranchAbs = 1'b0;

        // Mode and compare flag capture / hold
        NextState = 2'b01; CMPLoadEn = 1'b1; CMPBitsIn = 3'b011;
        step();
        check("mode_load", int'(CurrState), 1);
        check("cmp_load", int'(CMPBits), 3);
        CMPLoadEn = 1'b0; CMPBitsIn = 3'b100;
        step();
        check("cmp_hold", int'(CMPBits), 3);

        // Req while running is ignored
        Req = 1'b1;
        step();
        Req = 1'b0;
        check("req_in_run_pc", int'(ProgCtr), 'h1F3);
        check("req_in_run_cnt", int'(CycleCnt), 10);

        // Wrap 1023 -> 0
        BranchEn = 1'b1; BranchTarget = 9'h1FF;
        step();
        BranchTarget = 9'd13;
        step();
        BranchEn = 1'b0;
        check("pc_top", int'(ProgCtr), 1023);
        step();
        check("pc_wrap", int'(ProgCtr), 0);

        // Reset mid-run
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("midrst_pc", int'(ProgCtr), 0);
        check("midrst_running", int'(Running), 0);
        check("midrst_cmp", int'(CMPBits), 0);
        check("midrst_cnt", int'(CycleCnt), 0);
        check("midrst_instr", int'(Instruction), 0);

        // Fresh program, halt at PC 40 with a competing branch
        Req = 1'b1;
        step();
        Req = 1'b0;
        NextState = 2'b10; CMPLoadEn = 1'b1; CMPBitsIn = 3'b101;
        repeat (40) step();
        CMPLoadEn = 1'b0;
        check("pre_ack_pc", int'(ProgCtr), 40);
        AckIn = 1'b1; BranchEn = 1'b1; BranchAbs = 1'b1; BranchTarget = 9'd7;
        step();
        AckIn = 1'b0; BranchEn = 1'b0; BranchAbs = 1'b0;
        check("ack_pc", int'(ProgCtr), 40);
        check("ack_done", int'(Done), 1);
        check("ack_instr", int'(Instruction), 0);
        check("ack_cnt", int'(CycleCnt), 41);
        check("ack_cs_forced", int'(CurrState), 0);

        // Decoder outputs have no effect while halted
        BranchEn = 1'b1; CMPLoadEn = 1'b1; CMPBitsIn = 3'b010; AckIn = 1'b1;
        repeat (3) step();
        BranchEn = 1'b0; CMPLoadEn = 1'b0; AckIn = 1'b0;
        check("halt_pc", int'(ProgCtr), 40);
        check("halt_cmp", int'(CMPBits), 5);
        check("halt_cnt", int'(CycleCnt), 41);

        // Restart from halt
        Req = 1'b1;
        step();
        Req = 1'b0;
        check("restart_pc", int'(ProgCtr), 0);
        check("restart_cmp", int'(CMPBits), 0);
        check("restart_cnt", int'(CycleCnt), 0);
        check("restart_done", int'(Done), 0);
        check("restart_running", int'(Running), 1);

        // Counter saturation
        repeat (260) step();
        check("cnt_sat", int'(CycleCnt), CNT_MAX);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            Reset        = ($urandom_range(0, 499) == 0);
            Req          = ($urandom_range(0, 15) == 0);
            AckIn        = ($urandom_range(0, 299) == 0);
            BranchEn     = ($urandom_range(0, 7) == 0);
            BranchAbs    = 1'($urandom);
            BranchTarget = 9'($urandom);
            NextState    = 2'($urandom);
            PrevInstrIn  = 9'($urandom);
            CMPLoadEn    = 1'($urandom);
            CMPBitsIn    = 3'($urandom);
            step();
        end
        Reset = 1'b0; Req = 1'b0; AckIn = 1'b0; BranchEn = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
